dma_stream_out: RTL

- Downstream stage of the output buffer and interface path.
- Captures one completed N-point complex block (real/imag, flattened) in a single cycle when the output buffer signals readiness.
- Streams the block out one complex sample per transfer over a valid/ready handshake, with index and last-sample tagging.
- Reports completion and detects blocks that arrive while a previous block is still streaming.

---
 rtl/dsp_stream_pkg.sv | 17 +
 rtl/stream_block_store.sv | 40 ++++
 rtl/dma_stream_out.sv | 135 +++++++++++++
 3 files changed

// File: rtl/dsp_stream_pkg.sv
// Shared types and defaults for the output-buffer / DMA streaming path.
package dsp_stream_pkg;

    localparam int DSP_DATA_WIDTH = 16;
    localparam int DSP_N          = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } stream_state_e;

    // Index width for an N-point block; N is a power of two >= 2.
    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_block_store.sv
// N-entry complex register bank: single-cycle parallel load from flattened
// real/imag vectors, combinational indexed read.
module stream_block_store
    import dsp_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DSP_DATA_WIDTH,
    parameter int N          = DSP_N,
    parameter int IW         = index_width(DSP_N)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_load,
    input  logic [DATA_WIDTH*N-1:0] i_real,
    input  logic [DATA_WIDTH*N-1:0] i_imag,
    input  logic [IW-1:0]           i_rd_idx,
    output logic [DATA_WIDTH-1:0]   o_rd_real,
    output logic [DATA_WIDTH-1:0]   o_rd_imag
);

    logic [DATA_WIDTH-1:0] r_real [N];
    logic [DATA_WIDTH-1:0] r_imag [N];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < N; k++) begin
                r_real[k] <= '0;
                r_imag[k] <= '0;
            end
        end else if (i_load) begin
            for (int k = 0; k < N; k++) begin
                r_real[k] <= i_real[(k+1)*DATA_WIDTH-1 -: DATA_WIDTH];
                r_imag[k] <= i_imag[(k+1)*DATA_WIDTH-1 -: DATA_WIDTH];
            end
        end
    end

    assign o_rd_real = r_real[i_rd_idx];
    assign o_rd_imag = r_imag[i_rd_idx];

endmodule

// File: rtl/dma_stream_out.sv
// Captures a full complex block on buffer_ready and streams it one sample per
// valid/ready transfer. Optional drop counter: DMA_STREAM_DROP_CNT_EN.
module dma_stream_out
    import dsp_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DSP_DATA_WIDTH,
    parameter int N          = DSP_N
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    buffer_ready,
    input  logic [DATA_WIDTH*N-1:0] real_in,
    input  logic [DATA_WIDTH*N-1:0] imag_in,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [DATA_WIDTH-1:0]   out_real,
    output logic [DATA_WIDTH-1:0]   out_imag,
    output logic [$clog2(N)-1:0]    out_index,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done,
    output logic                    overrun
`ifdef DMA_STREAM_DROP_CNT_EN
    ,
    output logic [7:0]              drop_count
`endif
);

    localparam int IW = index_width(N);

    // Handshake: a sample moves when out_valid & out_ready at a rising edge;
    // while out_valid & !out_ready every sample field holds its value.
    stream_state_e         r_state;
    stream_state_e         w_state_nxt;
    logic                  w_load;
    logic                  w_advance;
    logic                  w_finish;
    logic                  w_drop;
    logic                  w_at_last;
    logic [IW-1:0]         w_next_idx;
    logic [DATA_WIDTH-1:0] w_rd_real;
    logic [DATA_WIDTH-1:0] w_rd_imag;

    assign w_at_last  = (out_index == IW'(N - 1));
    assign w_next_idx = out_index + 1'b1;

    stream_block_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .N          (N),
        .IW         (IW)
    ) u_store (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_load),
        .i_real    (real_in),
        .i_imag    (imag_in),
        .i_rd_idx  (w_next_idx),
        .o_rd_real (w_rd_real),
        .o_rd_imag (w_rd_imag)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_advance   = 1'b0;
        w_finish    = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            IDLE: begin
                if (buffer_ready) begin
                    w_load      = 1'b1;
                    w_state_nxt = STREAM;
                end
            end
            STREAM: begin
                // A new block cannot be taken until the held one has fully left.
                w_drop = buffer_ready;
                if (out_ready) begin
                    if (w_at_last) begin
                        w_finish    = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            out_index <= '0;
            out_real  <= '0;
            out_imag  <= '0;
            out_last  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            out_valid <= (w_state_nxt == STREAM);
            busy      <= (w_state_nxt == STREAM);
            done      <= w_finish;
            overrun   <= w_drop;
            // Sample 0 comes straight from the input bus; the store is being loaded this edge.
            if (w_load) begin
                out_index <= '0;
                out_real  <= real_in[DATA_WIDTH-1:0];
                out_imag  <= imag_in[DATA_WIDTH-1:0];
                out_last  <= 1'b0;
            end else if (w_advance) begin
                out_index <= w_next_idx;
                out_real  <= w_rd_real;
                out_imag  <= w_rd_imag;
                out_last  <= (w_next_idx == IW'(N - 1));
            end else if (w_finish) begin
                out_last  <= 1'b0;
            end
        end
    end

`ifdef DMA_STREAM_DROP_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_count <= '0;
        end else if (w_drop && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`endif

endmodule
